// File: rtl/mult18_share_sched_if.sv
// Requester-side and result-side signals of the shared 18x18 multiplier.
// master drives operands and stall/kill controls; slave is the scheduler.
interface mult18_share_sched_if;
   logic [3:0]  req_valid;
   logic [71:0] req_a;
   logic [71:0] req_b;
   logic [3:0]  req_ready;
   logic        hold;
   logic        flush;
   logic [35:0] p;
   logic        p_valid;
   logic [1:0]  p_id;
   logic        busy;

   modport master (
      output req_valid, req_a, req_b, hold, flush,
      input  req_ready, p, p_valid, p_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, hold, flush,
      output req_ready, p, p_valid, p_id, busy
   );
endinterface

// File: rtl/mult18_share_sched.sv
// Round-robin scheduler time-sharing one pipelined 18x18 signed multiplier
// among four requesters; HOLD acts as the multiplier clock enable.
module mult18_share_sched #(
   parameter int PIPE    = 2,
   parameter int RR_INIT = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mult18_share_sched_if.slave   bus
);

   localparam logic [1:0] PTR_RESET = RR_INIT[1:0];

   logic [1:0]        ptr_q, ptr_d;
   logic              grant_vld;
   logic [1:0]        grant_id;
   logic [3:0]        req_ready;

   logic signed [17:0] s0_a_q, s0_a_d, s0_b_q, s0_b_d;
   logic              s0_vld_q, s0_vld_d;
   logic [1:0]        s0_id_q, s0_id_d;

   logic signed [35:0] mul_prod_q [PIPE];
   logic signed [35:0] mul_prod_d [PIPE];
   logic [PIPE-1:0]   mul_vld_q, mul_vld_d;
   logic [1:0]        mul_id_q [PIPE];
   logic [1:0]        mul_id_d [PIPE];

   logic signed [35:0] p_q, p_d;
   logic              p_vld_q, p_vld_d;
   logic [1:0]        p_id_q, p_id_d;
   logic signed [35:0] prod;

   // Search starts at ptr_q; the 2-bit index sum wraps modulo 4 by itself.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant_vld = 1'b0;
      grant_id  = ptr_q;
      if (rst_n && !bus.hold && !bus.flush) begin
         for (int j = 0; j < 4; j++) begin
            if (!grant_vld && bus.req_valid[ptr_q + 2'(j)]) begin
               grant_vld = 1'b1;
               grant_id  = ptr_q + 2'(j);
            end
         end
      end
      req_ready = grant_vld ? (4'b0001 << grant_id) : 4'b0000;
   end

   always_comb begin
      ptr_d      = grant_vld ? grant_id + 2'd1 : ptr_q;
      s0_a_d     = s0_a_q;
      s0_b_d     = s0_b_q;
      s0_vld_d   = s0_vld_q;
      s0_id_d    = s0_id_q;
      mul_prod_d = mul_prod_q;
      mul_vld_d  = mul_vld_q;
      mul_id_d   = mul_id_q;
      p_d        = p_q;
      p_vld_d    = 1'b0;
      p_id_d     = p_id_q;
      prod       = s0_a_q * s0_b_q;

      if (bus.flush) begin
         s0_vld_d  = 1'b0;
         mul_vld_d = '0;
      end else if (!bus.hold) begin
         s0_vld_d = grant_vld;
         s0_id_d  = grant_id;
         if (grant_vld) begin
            s0_a_d = bus.req_a[18*grant_id +: 18];
            s0_b_d = bus.req_b[18*grant_id +: 18];
         end
         mul_prod_d[0] = prod;
         mul_vld_d[0]  = s0_vld_q;
         mul_id_d[0]   = s0_id_q;
         for (int i = 1; i < PIPE; i++) begin
            mul_prod_d[i] = mul_prod_q[i-1];
            mul_vld_d[i]  = mul_vld_q[i-1];
            mul_id_d[i]   = mul_id_q[i-1];
         end
         // P and P_ID only move on a real result; otherwise they hold.
         p_vld_d = mul_vld_q[PIPE-1];
         if (mul_vld_q[PIPE-1]) begin
            p_d    = mul_prod_q[PIPE-1];
            p_id_d = mul_id_q[PIPE-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= PTR_RESET;
         s0_vld_q  <= 1'b0;
         mul_vld_q <= '0;
         p_q       <= '0;
         p_vld_q   <= 1'b0;
         p_id_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         ptr_q     <= ptr_d;
         s0_vld_q  <= s0_vld_d;
         mul_vld_q <= mul_vld_d;
         p_q       <= p_d;
         p_vld_q   <= p_vld_d;
         p_id_q    <= p_id_d;
      end
   end

   // NOTE: pipeline data registers carry no reset; their valid bits qualify them, which keeps the reset net off the wide datapath.
   always_ff @(posedge clk) begin
      s0_a_q     <= s0_a_d;
      s0_b_q     <= s0_b_d;
      s0_id_q    <= s0_id_d;
      mul_prod_q <= mul_prod_d;
      mul_id_q   <= mul_id_d;
   end

   assign bus.req_ready = req_ready;
   assign bus.p         = p_q;
   assign bus.p_valid   = p_vld_q;
   assign bus.p_id      = p_id_q;
   assign bus.busy      = s0_vld_q | (|mul_vld_q) | p_vld_q;

endmodule

// File: tb/tb_mult18_share_sched.sv
// Directed bench for mult18_share_sched (PIPE=2, RR_INIT=0): arbitration,
// latency, HOLD, FLUSH, async reset and corner operands.
module tb_mult18_share_sched;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   logic signed [17:0] op_a  [4];
   logic signed [17:0] op_b  [4];
   logic signed [35:0] exp_p [4];

   mult18_share_sched_if bus();

   mult18_share_sched #(.PIPE(2), .RR_INIT(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ops();
      for (int i = 0; i < 4; i++) begin
         bus.req_a[18*i +: 18] = op_a[i];
         bus.req_b[18*i +: 18] = op_b[i];
      end
   endtask

   task automatic check_out(input string tag, input logic exp_v, input int id);
      check({tag, "_vld"}, 36'(bus.p_valid), 36'(exp_v));
      if (exp_v) begin
         check({tag, "_p"},  bus.p, exp_p[id]);
         check({tag, "_id"}, 36'(bus.p_id), 36'(id));
      end
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      bus.hold      = 1'b0;
      bus.flush     = 1'b0;
      rst_n         = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_ops_main();
      op_a  = '{18'sd7, -18'sd2, 18'sd100, -18'sd131072};
      op_b  = '{-18'sd3, -18'sd9, 18'sd255, 18'sd2};
      exp_p = '{-36'sd21, 36'sd18, 36'sd25500, -36'sd262144};
      load_ops();
   endtask

   initial begin
      logic [3:0] exp_rdy;
      int         sched [9];

      bus.req_valid = 4'hF;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.hold      = 1'b0;
      bus.flush     = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", 36'(bus.req_ready), 36'h0);
      check("rst_p",     bus.p, 36'h0);
      check("rst_pvld",  36'(bus.p_valid), 36'h0);
      check("rst_pid",   36'(bus.p_id), 36'h0);
      check("rst_busy",  36'(bus.busy), 36'h0);
      do_reset();

      // Single op: requester 2, 3 * -5, visible after edge k+3.
      op_a  = '{18'sd0, 18'sd0, 18'sd3, 18'sd0};
      op_b  = '{18'sd0, 18'sd0, -18'sd5, 18'sd0};
      exp_p = '{36'sd0, 36'sd0, -36'sd15, 36'sd0};
      load_ops();
      bus.req_valid = 4'b0100;
      #1 check("single_ready", 36'(bus.req_ready), 36'b0100);
      tick();
      bus.req_valid = '0;
      check("single_busy_k", 36'(bus.busy), 36'h1);
      tick();
      check_out("single_k1", 1'b0, 0);
      tick();
      check_out("single_k2", 1'b0, 0);
      tick();
      check_out("single_k3", 1'b1, 2);
      tick();
      check_out("single_k4", 1'b0, 0);
      check("single_busy_k4", 36'(bus.busy), 36'h0);
      check("single_p_hold", bus.p, exp_p[2]);

      // Pointer is now 3: the search wraps 3 -> 0.
      bus.req_valid = 4'b0011;
      #1 check("wrap_ready_a", 36'(bus.req_ready), 36'b0001);
      bus.req_valid = 4'b1001;
      #1 check("wrap_ready_b", 36'(bus.req_ready), 36'b1000);
      bus.req_valid = '0;

      // All four requesting: grants 0,1,2,3,... results back-to-back.
      do_reset();
      set_ops_main();
      bus.req_valid = 4'hF;
      for (int n = 0; n < 12; n++) begin
         if (n < 8) begin
            exp_rdy = 4'b0001 << (n % 4);
            #1 check($sformatf("rr_ready%0d", n), 36'(bus.req_ready), 36'(exp_rdy));
         end
         tick();
         if (n == 7) bus.req_valid = '0;
         check_out($sformatf("rr_out%0d", n), (n >= 3 && n <= 10), (n >= 3) ? (n - 3) % 4 : 0);
      end
      check("rr_busy_end", 36'(bus.busy), 36'h0);

      // HOLD over edges 4 and 5 with three ops in flight: last result 2 late.
      do_reset();
      set_ops_main();
      sched = '{-1, -1, -1, 0, -1, -1, 1, 2, -1};
      bus.req_valid = 4'b0111;
      for (int n = 0; n < 9; n++) begin
         if (n == 3) bus.req_valid = '0;
         if (n == 4) begin
            bus.hold      = 1'b1;
            bus.req_valid = 4'b1000;
            #1 check("hold_ready", 36'(bus.req_ready), 36'h0);
         end
         if (n == 6) begin
            bus.hold      = 1'b0;
            bus.req_valid = '0;
         end
         tick();
         check_out($sformatf("hold_e%0d", n), sched[n] >= 0, (sched[n] >= 0) ? sched[n] : 0);
         if (n == 4 || n == 5) begin
            check($sformatf("hold_p_keep%0d", n), bus.p, exp_p[0]);
            check($sformatf("hold_busy%0d", n), 36'(bus.busy), 36'h1);
         end
      end

      // FLUSH together with HOLD: flush wins, pipeline empties, pointer kept.
      do_reset();
      set_ops_main();
      bus.req_valid = 4'b0111;
      tick();
      tick();
      tick();
      bus.flush     = 1'b1;
      bus.hold      = 1'b1;
      bus.req_valid = 4'hF;
      #1 check("flush_ready", 36'(bus.req_ready), 36'h0);
      tick();
      bus.flush = 1'b0;
      bus.hold  = 1'b0;
      check("flush_pvld", 36'(bus.p_valid), 36'h0);
      check("flush_busy", 36'(bus.busy), 36'h0);
      #1 check("flush_ptr", 36'(bus.req_ready), 36'b1000);
      bus.req_valid = '0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check($sformatf("flush_stale%0d", n), 36'(bus.p_valid), 36'h0);
      end
      bus.req_valid = 4'b1000;
      tick();
      bus.req_valid = '0;
      tick();
      check_out("flush_new1", 1'b0, 0);
      tick();
      check_out("flush_new2", 1'b0, 0);
      tick();
      check_out("flush_new3", 1'b1, 3);

      // Async reset mid-pipeline: outputs clear at once, nothing stale later.
      do_reset();
      set_ops_main();
      bus.req_valid = 4'b0111;
      tick();
      tick();
      tick();
      bus.req_valid = '0;
      tick();
      check_out("mid_before", 1'b1, 0);
      #3 rst_n = 1'b0;
      #1;
      check("mid_p",    bus.p, 36'h0);
      check("mid_pvld", 36'(bus.p_valid), 36'h0);
      check("mid_pid",  36'(bus.p_id), 36'h0);
      check("mid_busy", 36'(bus.busy), 36'h0);
      bus.req_valid = 4'hF;
      #1 check("mid_ready", 36'(bus.req_ready), 36'h0);
      tick();
      bus.req_valid = '0;
      rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         check($sformatf("mid_stale%0d", n), 36'(bus.p_valid), 36'h0);
      end
      bus.req_valid = 4'hF;
      #1 check("mid_ptr_init", 36'(bus.req_ready), 36'b0001);
      bus.req_valid = '0;

      // Corner operands.
      do_reset();
      op_a  = '{-18'sd131072, 18'sd131071, 18'sd0, -18'sd1};
      op_b  = '{-18'sd131072, -18'sd131072, -18'sd77777, -18'sd1};
      exp_p = '{36'h400000000, -36'sd17179738112, 36'sd0, 36'sd1};
      load_ops();
      bus.req_valid = 4'hF;
      for (int n = 0; n < 7; n++) begin
         tick();
         if (n == 3) bus.req_valid = '0;
         if (n >= 3) check_out($sformatf("corner%0d", n - 3), 1'b1, n - 3);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
